// File: rtl/fp_dot_pkg.sv
// Shared widths and the lane record for the 4D dot-product datapath.
// Lanes carry sign, biased exponent and significand magnitude.
package fp_dot_pkg;

    localparam int SIG_W = 50;
    localparam int EXP_W = 8;
    localparam int OUT_W = SIG_W + 1;
    localparam int SH_W  = $clog2(SIG_W + 1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } lane_t;

endpackage

// File: rtl/pip_align_shift.sv
// Saturating right shifter for one lane: produces the aligned signed value
// and the sticky OR of every bit shifted out.
module align_shift
    import fp_dot_pkg::*;
(
    input  logic             i_sign,
    input  logic [SIG_W-1:0] i_sig,
    input  logic [EXP_W-1:0] i_diff,
    output logic [OUT_W-1:0] o_al,
    output logic             o_sticky
);

    logic [SH_W-1:0]  w_sh;
    logic [SIG_W-1:0] w_mag;
    logic [SIG_W-1:0] w_mask;
    logic [OUT_W-1:0] w_ext;

    // Shifting by SIG_W empties the lane, so larger distances collapse to SIG_W.
    always_comb begin
        if (int'(i_diff) >= SIG_W) begin
            w_sh = SH_W'(SIG_W);
        end else begin
            w_sh = i_diff[SH_W-1:0];
        end
        w_mag    = i_sig >> w_sh;
        w_mask   = ~({SIG_W{1'b1}} << w_sh);
        o_sticky = |(i_sig & w_mask);
        w_ext    = {1'b0, w_mag};
        o_al     = i_sign ? (-w_ext) : w_ext;
    end

endmodule

// File: rtl/pip_align.sv
// Stage-2 product consumer: finds the maximum exponent, aligns all four lanes
// to it and hands signed lanes to the adder tree over a two-stage pipeline.
module pip_align
    import fp_dot_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign0,
    input  logic             sign1,
    input  logic             sign2,
    input  logic             sign3,
    input  logic [EXP_W-1:0] exp0,
    input  logic [EXP_W-1:0] exp1,
    input  logic [EXP_W-1:0] exp2,
    input  logic [EXP_W-1:0] exp3,
    input  logic [SIG_W-1:0] sig_out0,
    input  logic [SIG_W-1:0] sig_out1,
    input  logic [SIG_W-1:0] sig_out2,
    input  logic [SIG_W-1:0] sig_out3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] max_exp,
    output logic [OUT_W-1:0] al0,
    output logic [OUT_W-1:0] al1,
    output logic [OUT_W-1:0] al2,
    output logic [OUT_W-1:0] al3,
    output logic             sticky0,
    output logic             sticky1,
    output logic             sticky2,
    output logic             sticky3
);

    lane_t [3:0]            w_in;
    logic [EXP_W-1:0]       w_max01;
    logic [EXP_W-1:0]       w_max23;
    logic [EXP_W-1:0]       w_max_e;
    logic [3:0][EXP_W-1:0]  w_diff;
    logic [3:0][OUT_W-1:0]  w_al;
    logic [3:0]             w_sticky;
    logic                   w_s2_adv;
    logic                   w_accept;

    logic                   r_s1_valid;
    lane_t [3:0]            r_s1_lane;
    logic [EXP_W-1:0]       r_s1_max;
    logic                   r_s2_valid;
    logic [3:0][OUT_W-1:0]  r_al;
    logic [3:0]             r_sticky;
    logic [EXP_W-1:0]       r_max_exp;

    always_comb begin
        w_in[0] = {sign0, exp0, sig_out0};
        w_in[1] = {sign1, exp1, sig_out1};
        w_in[2] = {sign2, exp2, sig_out2};
        w_in[3] = {sign3, exp3, sig_out3};
        w_max01 = (exp0 > exp1) ? exp0 : exp1;
        w_max23 = (exp2 > exp3) ? exp2 : exp3;
        w_max_e = (w_max01 > w_max23) ? w_max01 : w_max23;
    end

    // max_e is the largest exponent, so these differences never wrap.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_diff[i] = r_s1_max - r_s1_lane[i].exp;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        align_shift u_shift (
            .i_sign   (r_s1_lane[g].sign),
            .i_sig    (r_s1_lane[g].sig),
            .i_diff   (w_diff[g]),
            .o_al     (w_al[g]),
            .o_sticky (w_sticky[g])
        );
    end

    assign w_s2_adv = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready = rst && (!r_s1_valid || w_s2_adv);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_lane  <= '0;
            r_s1_max   <= '0;
            r_s2_valid <= 1'b0;
            r_al       <= '0;
            r_sticky   <= '0;
            r_max_exp  <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_lane <= w_in;
                r_s1_max  <= w_max_e;
            end
            // S2 only reloads on an advance, which keeps outputs frozen during a stall.
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_al       <= w_al;
                r_sticky   <= w_sticky;
                r_max_exp  <= r_s1_max;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign max_exp   = r_max_exp;
    assign al0       = r_al[0];
    assign al1       = r_al[1];
    assign al2       = r_al[2];
    assign al3       = r_al[3];
    assign sticky0   = r_sticky[0];
    assign sticky1   = r_sticky[1];
    assign sticky2   = r_sticky[2];
    assign sticky3   = r_sticky[3];

endmodule

// File: tb/tb_pip_align.sv
// Self-checking bench for pip_align: directed alignment cases plus randomized
// traffic against an arithmetic reference model and an in-order expectation queue.
module tb_pip_align;

    typedef struct packed {
        logic [3:0]        sgn;
        logic [3:0][7:0]   e;
        logic [3:0][49:0]  s;
    } vec_t;

    typedef struct packed {
        logic [7:0]        mx;
        logic [3:0][50:0]  al;
        logic [3:0]        st;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign0, sign1, sign2, sign3;
    logic [7:0]  exp0, exp1, exp2, exp3;
    logic [49:0] sig_out0, sig_out1, sig_out2, sig_out3;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  max_exp;
    logic [50:0] al0, al1, al2, al3;
    logic        sticky0, sticky1, sticky2, sticky3;

    int   checks = 0;
    int   failures = 0;
    vec_t cur;
    res_t expq[$];

    pip_align dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign0(sign0), .sign1(sign1), .sign2(sign2), .sign3(sign3),
        .exp0(exp0), .exp1(exp1), .exp2(exp2), .exp3(exp3),
        .sig_out0(sig_out0), .sig_out1(sig_out1), .sig_out2(sig_out2), .sig_out3(sig_out3),
        .out_valid(out_valid), .out_ready(out_ready), .max_exp(max_exp),
        .al0(al0), .al1(al1), .al2(al2), .al3(al3),
        .sticky0(sticky0), .sticky1(sticky1), .sticky2(sticky2), .sticky3(sticky3)
    );

    always #5 clk = ~clk;

    // Reference: align by plain integer division semantics on 64-bit values.
    function automatic res_t model(input vec_t v);
        res_t        r;
        logic [63:0] sv;
        logic [63:0] mag;
        int          mx;
        int          d;
        r  = '0;
        mx = 0;
        for (int i = 0; i < 4; i++) if (int'(v.e[i]) > mx) mx = int'(v.e[i]);
        r.mx = 8'(mx);
        for (int i = 0; i < 4; i++) begin
            d  = mx - int'(v.e[i]);
            sv = 64'(v.s[i]);
            if (d >= 50) begin
                mag     = 64'd0;
                r.st[i] = (sv != 64'd0);
            end else begin
                mag     = sv >> d;
                r.st[i] = ((mag << d) != sv);
            end
            r.al[i] = v.sgn[i] ? 51'(64'd0 - mag) : 51'(mag);
        end
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.mx    = max_exp;
        r.al[0] = al0;
        r.al[1] = al1;
        r.al[2] = al2;
        r.al[3] = al3;
        r.st    = {sticky3, sticky2, sticky1, sticky0};
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int   base;
        base  = $urandom_range(0, 190);
        v.sgn = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            v.e[i] = 8'(base + $urandom_range(0, 64));
            v.s[i] = 50'({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) v.s[i] = 50'($urandom_range(0, 255));
        end
        return v;
    endfunction

    task automatic drive(input vec_t v, input logic vld);
        cur      = v;
        in_valid = vld;
        {sign3, sign2, sign1, sign0} = v.sgn;
        exp0 = v.e[0]; exp1 = v.e[1]; exp2 = v.e[2]; exp3 = v.e[3];
        sig_out0 = v.s[0]; sig_out1 = v.s[1]; sig_out2 = v.s[2]; sig_out3 = v.s[3];
    endtask

    // One clock: records transfers on the edge and keeps the expectation queue in order.
    task automatic tick(output logic acc, output logic con);
        #1;
        acc = rst && in_valid && in_ready;
        con = out_valid && out_ready;
        @(posedge clk);
        if (!rst) begin
            expq.delete();
        end else begin
            if (con) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL spurious_output got=%h required=<nothing pending>", observed());
                end else begin
                    void'(expq.pop_front());
                end
            end
            if (acc) expq.push_back(model(cur));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic a, c;
        res_t o;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(rand_vec(), 1'b1);
        repeat (3) begin
            tick(a, c);
            o = observed();
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b required=0", out_valid); end
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready got=%b required=0", in_ready); end
            checks++;
            if (o !== '0) begin failures++; $display("[TB] FAIL rst_outputs got=%h required=0", o); end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready got=%b required=1", in_ready); end
        tick(a, c);
        drive(cur, 1'b0);
        tick(a, c);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL first_accept_valid got=%b required=1", out_valid); end
        checks++;
        if (expq.size() == 0 || observed() !== expq[0]) begin
            failures++; $display("[TB] FAIL first_accept_data got=%h", observed());
        end
        tick(a, c);
    endtask

    task automatic test_basic();
        logic a, c;
        vec_t v;
        res_t o;
        logic [50:0] neg80;
        neg80 = 51'd0 - 51'h80;
        v.e   = {8'd8, 8'd12, 8'd12, 8'd10};
        v.s   = {50'h1F, 50'h80, 50'h100, 50'h3};
        v.sgn = 4'b0100;
        out_ready = 1'b1;
        drive(v, 1'b1);
        tick(a, c);
        drive(v, 1'b0);
        tick(a, c);
        o = observed();
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid got=%b required=1", out_valid); end
        checks++;
        if (o.mx !== 8'd12) begin failures++; $display("[TB] FAIL basic_max got=%0d required=12", o.mx); end
        checks++;
        if (o.al[0] !== 51'd0 || o.st[0] !== 1'b1) begin failures++; $display("[TB] FAIL basic_lane0 got=%h/%b required=0/1", o.al[0], o.st[0]); end
        checks++;
        if (o.al[1] !== 51'h100 || o.st[1] !== 1'b0) begin failures++; $display("[TB] FAIL basic_lane1 got=%h/%b required=100/0", o.al[1], o.st[1]); end
        checks++;
        if (o.al[2] !== neg80) begin failures++; $display("[TB] FAIL basic_lane2 got=%h required=%h", o.al[2], neg80); end
        checks++;
        if (o.al[3] !== 51'd1 || o.st[3] !== 1'b1) begin failures++; $display("[TB] FAIL basic_lane3 got=%h/%b required=1/1", o.al[3], o.st[3]); end
        checks++;
        if (expq.size() == 0 || o !== expq[0]) begin failures++; $display("[TB] FAIL basic_model got=%h", o); end
        tick(a, c);
    endtask

    task automatic test_saturation();
        logic a, c;
        vec_t v;
        res_t o;
        v.e   = {8'd10, 8'd10, 8'd10, 8'd200};
        v.s   = {50'h2_0000_0000_0000, 50'h2_0000_0000_0000, 50'h1, 50'h2_0000_0000_0000};
        v.sgn = 4'b0000;
        out_ready = 1'b1;
        drive(v, 1'b1);
        tick(a, c);
        drive(v, 1'b0);
        tick(a, c);
        o = observed();
        checks++;
        if (o.mx !== 8'd200) begin failures++; $display("[TB] FAIL sat_max got=%0d required=200", o.mx); end
        checks++;
        if (o.al[1] !== 51'd0 || o.al[2] !== 51'd0 || o.al[3] !== 51'd0) begin
            failures++; $display("[TB] FAIL sat_lanes got=%h,%h,%h required=0", o.al[1], o.al[2], o.al[3]);
        end
        checks++;
        if (o.st !== 4'b1110) begin failures++; $display("[TB] FAIL sat_sticky got=%b required=1110", o.st); end
        checks++;
        if (o.al[0] !== 51'h2_0000_0000_0000) begin failures++; $display("[TB] FAIL sat_lane0 got=%h required=2000000000000", o.al[0]); end
        tick(a, c);
    endtask

    task automatic test_negzero();
        logic a, c;
        vec_t v;
        res_t o;
        logic [50:0] neg7;
        neg7  = 51'd0 - 51'd7;
        v.e   = {8'd5, 8'd5, 8'd5, 8'd5};
        v.s   = {50'd9, 50'd7, 50'd5, 50'd0};
        v.sgn = 4'b0101;
        out_ready = 1'b1;
        drive(v, 1'b1);
        tick(a, c);
        drive(v, 1'b0);
        tick(a, c);
        o = observed();
        checks++;
        if (o.al[0] !== 51'd0) begin failures++; $display("[TB] FAIL negzero_al0 got=%h required=0", o.al[0]); end
        checks++;
        if (o.st !== 4'b0000) begin failures++; $display("[TB] FAIL equal_exp_sticky got=%b required=0000", o.st); end
        checks++;
        if (o.al[1] !== 51'd5 || o.al[2] !== neg7 || o.al[3] !== 51'd9) begin
            failures++; $display("[TB] FAIL equal_exp_lanes got=%h,%h,%h", o.al[1], o.al[2], o.al[3]);
        end
        tick(a, c);
    endtask

    task automatic test_backpressure();
        logic a, c;
        vec_t bv[5];
        res_t o;
        res_t prev_o;
        logic prev_stall;
        int   sent;
        int   recv;
        logic drop_seen;
        for (int i = 0; i < 5; i++) bv[i] = rand_vec();
        sent = 0; recv = 0; prev_stall = 1'b0; prev_o = '0; drop_seen = 1'b0;
        for (int cy = 1; cy <= 40 && recv < 5; cy++) begin
            out_ready = !(cy >= 2 && cy <= 6);
            if (sent < 5) drive(bv[sent], 1'b1); else drive(cur, 1'b0);
            #1;
            o = observed();
            if (out_valid) begin
                checks++;
                if (expq.size() == 0 || o !== expq[0]) begin failures++; $display("[TB] FAIL bp_data got=%h", o); end
            end
            if (prev_stall && out_valid) begin
                checks++;
                if (o !== prev_o) begin failures++; $display("[TB] FAIL bp_stable got=%h required=%h", o, prev_o); end
            end
            if (!in_ready && !drop_seen && sent < 5) begin
                drop_seen = 1'b1;
                checks++;
                if (sent != 2) begin failures++; $display("[TB] FAIL bp_ready_drop got=%0d accepted required=2", sent); end
            end
            prev_stall = out_valid && !out_ready;
            prev_o     = o;
            tick(a, c);
            if (a) sent++;
            if (c) recv++;
        end
        checks++;
        if (recv != 5 || expq.size() != 0) begin failures++; $display("[TB] FAIL bp_count got=%0d pending=%0d required=5/0", recv, expq.size()); end
    endtask

    task automatic test_throughput();
        logic a, c;
        vec_t tv[8];
        for (int i = 0; i < 8; i++) tv[i] = rand_vec();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) drive(tv[i], 1'b1); else drive(cur, 1'b0);
            #1;
            if (i < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL tp_ready cycle=%0d got=%b required=1", i, in_ready); end
            end
            checks++;
            if (out_valid !== (i >= 2 && i <= 9)) begin failures++; $display("[TB] FAIL tp_valid cycle=%0d got=%b", i, out_valid); end
            if (out_valid) begin
                checks++;
                if (expq.size() == 0 || observed() !== expq[0]) begin failures++; $display("[TB] FAIL tp_data got=%h", observed()); end
            end
            tick(a, c);
        end
    endtask

    task automatic test_random();
        logic a, c;
        for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(rand_vec(), 1'($urandom_range(0, 1)));
            #1;
            if (out_valid) begin
                checks++;
                if (expq.size() == 0 || observed() !== expq[0]) begin failures++; $display("[TB] FAIL rand_data got=%h", observed()); end
            end
            tick(a, c);
        end
        out_ready = 1'b1;
        drive(cur, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin
                checks++;
                if (expq.size() == 0 || observed() !== expq[0]) begin failures++; $display("[TB] FAIL rand_drain got=%h", observed()); end
            end
            tick(a, c);
        end
        checks++;
        if (expq.size() != 0) begin failures++; $display("[TB] FAIL rand_lost got=%0d pending required=0", expq.size()); end
    endtask

    task automatic test_reset_mid();
        logic a, c;
        out_ready = 1'b0;
        drive(rand_vec(), 1'b1);
        tick(a, c);
        drive(rand_vec(), 1'b1);
        tick(a, c);
        rst = 1'b0;
        tick(a, c);
        rst = 1'b1;
        out_ready = 1'b1;
        drive(cur, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(a, c);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_replay cycle=%0d got=%b required=0", i, out_valid); end
        end
    endtask

    initial begin
        rst = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0);
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturation();
        test_negzero();
        test_backpressure();
        test_throughput();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
